combi_truth_table_scanner: RTL and testbench

//  Sequencer for the 3-input combinational CombiCircuit (a,b,c -> y). On start, drives all
//  2**N_IN input vectors in ascending order. Holds each vector for a programmable dwell, then

---
 rtl/combi_truth_table_scanner_pkg.sv | 21 ++
 rtl/combi_truth_table_scanner_if.sv | 33 +++
 rtl/combi_truth_table_scanner_dwell_timer.sv | 47 ++++
 rtl/combi_truth_table_scanner.sv | 127 ++++++++++++
 tb/tb_combi_truth_table_scanner.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/combi_truth_table_scanner_pkg.sv
// rtl/combi_truth_table_scanner_pkg.sv - shared types, defaults and helpers for the truth-table scanner
// Purpose: scan FSM state type, default widths and the effective-dwell helper.
// Ports: none (package).
package combi_scan_pkg;

  localparam int N_IN_DEF    = 3;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  // A dwell of zero would leave no drive cycle, so it is promoted to one.
  function automatic logic [DWELL_W_DEF-1:0] dwell_eff(input logic [DWELL_W_DEF-1:0] dwell);
    return (dwell == '0) ? DWELL_W_DEF'(1) : dwell;
  endfunction

endpackage

// File: rtl/combi_truth_table_scanner_if.sv
// rtl/combi_truth_table_scanner_if.sv - host/circuit-facing signal bundle of the truth-table scanner
// Purpose: groups start/dwell control, the circuit drive/return pair and the result outputs.
// Signals: start, dwell, y_in (host/circuit -> scanner); abc, busy, done, truth (scanner -> host/circuit).
// Optional (COMBI_SCAN_COMPARE_EN): expected (host -> scanner); mismatch, pass (scanner -> host).
interface combi_truth_table_scanner_if
  import combi_scan_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);
  logic                 start;
  logic [DWELL_W-1:0]   dwell;
  logic [N_IN-1:0]      abc;
  logic                 y_in;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   truth;
`ifdef COMBI_SCAN_COMPARE_EN
  logic [2**N_IN-1:0]   expected;
  logic [2**N_IN-1:0]   mismatch;
  logic                 pass;

  modport master (output start, dwell, y_in, expected,
                  input  abc, busy, done, truth, mismatch, pass);
  modport slave  (input  start, dwell, y_in, expected,
                  output abc, busy, done, truth, mismatch, pass);
`else
  modport master (output start, dwell, y_in,
                  input  abc, busy, done, truth);
  modport slave  (input  start, dwell, y_in,
                  output abc, busy, done, truth);
`endif
endinterface

// File: rtl/combi_truth_table_scanner_dwell_timer.sv
// rtl/combi_truth_table_scanner_dwell_timer.sv - per-vector dwell counter for the truth-table scanner
// Purpose: holds the latched dwell and counts drive cycles of the current vector.
// Ports: clk, rst (async, active-high); load latches limit and clears the count;
//        clr clears the count only; en advances it; expire flags the last drive cycle.
module combi_dwell_timer
  import combi_scan_pkg::*;
#(
  parameter int W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] lim_q, lim_d;
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    lim_d = lim_q;
    cnt_d = cnt_q;
    if (load) begin
      lim_d = limit;
      cnt_d = '0;
    end else if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_q <= '0;
      cnt_q <= '0;
    end else begin
      lim_q <= lim_d;
      cnt_q <= cnt_d;
    end
  end

  // limit is never zero once loaded, so limit-1 cannot wrap during a scan.
  assign expire = (cnt_q == lim_q - 1'b1);

endmodule

// File: rtl/combi_truth_table_scanner.sv
// rtl/combi_truth_table_scanner.sv - sequencer that sweeps a 3-input circuit and captures its truth table
// Purpose: on start, drives every input vector in ascending order, holds each for the latched
//          dwell plus one sample cycle, and records y into truth[k].
// Ports: clk; rst (async, active-high); bus (slave modport): start, dwell, y_in in;
//        abc, busy, done, truth out.
// Config: COMBI_SCAN_COMPARE_EN adds expected in, mismatch/pass out on the bus.
module combi_truth_table_scanner
  import combi_scan_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  combi_truth_table_scanner_if.slave   bus
);
  localparam int              N_VEC  = 2**N_IN;
  localparam logic [N_IN-1:0] K_LAST = N_IN'(N_VEC - 1);

  scan_state_t        state_q, state_d;
  logic [N_IN-1:0]    k_q, k_d;
  logic [N_VEC-1:0]   truth_q, truth_d;
  logic               tmr_load, tmr_clr, tmr_en, tmr_expire;
  logic [DWELL_W-1:0] dwell_use;

  assign dwell_use = dwell_eff(bus.dwell);

  combi_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .limit  (dwell_use),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    truth_d  = truth_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tmr_load = 1'b1;
          k_d      = '0;
          truth_d  = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        truth_d[k_q] = bus.y_in;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          tmr_clr = 1'b1;
          state_d = DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      truth_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      truth_q <= truth_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  assign bus.abc   = (state_q == DRIVE || state_q == SAMPLE) ? k_q : '0;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.truth = truth_q;

`ifdef COMBI_SCAN_COMPARE_EN
  logic [N_VEC-1:0] exp_q, exp_d;
  logic [N_VEC-1:0] mm_q, mm_d;
  logic             pass_q, pass_d;

  always_comb begin
    exp_d  = exp_q;
    mm_d   = mm_q;
    pass_d = pass_q;
    if (state_q == IDLE && bus.start) begin
      exp_d  = bus.expected;
      mm_d   = '0;
      pass_d = 1'b0;
    end else if (state_q == SAMPLE && k_q == K_LAST) begin
      // truth_d already holds the final bit, so the verdict is ready in the DONE cycle.
      mm_d   = truth_d ^ exp_q;
      pass_d = (truth_d == exp_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q  <= '0;
      mm_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      mm_q   <= mm_d;
      pass_q <= pass_d;
    end
  end

  assign bus.mismatch = mm_q;
  assign bus.pass     = pass_q;
`endif

endmodule

// File: tb/tb_combi_truth_table_scanner.sv
// tb/tb_combi_truth_table_scanner.sv - self-checking bench for the truth-table scanner
module tb_combi_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tbl = 8'hBA;

  always #5 clk = ~clk;

  combi_truth_table_scanner_if bus ();

  combi_truth_table_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the combinational circuit: y is the table bit selected by abc.
  assign bus.y_in = tbl[bus.abc];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: time since acceptance t and latched dwell D fully determine outputs.
  logic       m_active;
  int         m_t;
  int         m_d;
  logic [7:0] m_tbl;
  logic [7:0] m_truth;
`ifdef COMBI_SCAN_COMPARE_EN
  logic [7:0] m_exp;
  logic [7:0] m_mm;
  logic       m_pass;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_d      <= 1;
      m_tbl    <= 8'h00;
      m_truth  <= 8'h00;
`ifdef COMBI_SCAN_COMPARE_EN
      m_exp    <= 8'h00;
      m_mm     <= 8'h00;
      m_pass   <= 1'b0;
`endif
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t + 1 > 8 * (m_d + 1)) m_active <= 1'b0;
      if ((m_t + 1) % (m_d + 1) == 0 && (m_t + 1) <= 8 * (m_d + 1))
        m_truth[(m_t + 1) / (m_d + 1) - 1] <= m_tbl[(m_t + 1) / (m_d + 1) - 1];
`ifdef COMBI_SCAN_COMPARE_EN
      if (m_t + 1 == 8 * (m_d + 1)) begin
        m_mm   <= m_tbl ^ m_exp;
        m_pass <= (m_tbl == m_exp);
      end
`endif
    end else if (bus.start) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_d      <= (bus.dwell == 8'd0) ? 1 : int'(bus.dwell);
      m_tbl    <= tbl;
      m_truth  <= 8'h00;
`ifdef COMBI_SCAN_COMPARE_EN
      m_exp    <= bus.expected;
      m_mm     <= 8'h00;
      m_pass   <= 1'b0;
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic cycle_check();
    int   e_abc;
    logic e_busy, e_done;
    logic ok;
    e_busy = m_active;
    e_done = m_active && (m_t == 8 * (m_d + 1));
    e_abc  = (m_active && m_t < 8 * (m_d + 1)) ? m_t / (m_d + 1) : 0;
    ok = (bus.abc === 3'(e_abc)) && (bus.busy === e_busy) &&
         (bus.done === e_done) && (bus.truth === m_truth);
`ifdef COMBI_SCAN_COMPARE_EN
    ok = ok && (bus.mismatch === m_mm) && (bus.pass === m_pass);
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL cycle: abc=%0d/%0d busy=%b/%b done=%b/%b truth=%h/%h (got/want) at %0t",
               bus.abc, e_abc, bus.busy, e_busy, bus.done, e_done, bus.truth, m_truth, $time);
    end
  endtask

  // Pulse start, then report the cycle offset at which done appears (bounded).
  task automatic scan(input logic [7:0] d, input logic [7:0] t, input int lat, input string nm);
    int cnt;
    tbl = t;
    bus.dwell = d;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, " done latency"}, cnt, lat);
    chk({nm, " truth"}, bus.truth, t);
`ifdef COMBI_SCAN_COMPARE_EN
    chk({nm, " mismatch"}, bus.mismatch, t ^ bus.expected);
    chk({nm, " pass"}, bus.pass, (t == bus.expected));
`endif
    @(negedge clk);
    chk({nm, " busy after"}, bus.busy, 1'b0);
    chk({nm, " done after"}, bus.done, 1'b0);
  endtask

  initial begin
    int n_done, first, cnt;
    bus.start = 1'b0;
    bus.dwell = 8'd0;
`ifdef COMBI_SCAN_COMPARE_EN
    bus.expected = 8'hBA;
`endif
    fork
      forever begin
        @(posedge clk);
        #1;
        cycle_check();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset abc", bus.abc, 3'd0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset truth", bus.truth, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Reference circuit y = (a & ~b) | c.
    scan(8'd3, 8'hBA, 32, "t1 dwell3");
    scan(8'd0, 8'hBA, 16, "t2 dwell0");

    // Re-pulsed start mid-scan must be ignored.
    tbl = 8'hBA;
    bus.dwell = 8'd3;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n_done = 0;
    first = -1;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) bus.start = 1'b1;
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    chk("t3 done count", n_done, 1);
    chk("t3 done cycle", first, 32);

    // Reset in the middle of a scan.
    bus.dwell = 8'd3;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4 abc", bus.abc, 3'd0);
    chk("t4 busy", bus.busy, 1'b0);
    chk("t4 truth", bus.truth, 8'h00);
    chk("t4 done", bus.done, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    scan(8'd3, 8'hBA, 32, "t4 rescan");

    // start held high: second scan follows the IDLE cycle after DONE with cleared truth.
    bus.dwell = 8'd1;
    @(negedge clk) bus.start = 1'b1;
    cnt = 0;
    while (!bus.done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5 first done", bus.done, 1'b1);
    @(negedge clk);
    chk("t5 idle busy", bus.busy, 1'b0);
    chk("t5 idle truth", bus.truth, 8'hBA);
    @(negedge clk);
    chk("t5 restart busy", bus.busy, 1'b1);
    chk("t5 restart truth", bus.truth, 8'h00);
    bus.start = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5 second truth", bus.truth, 8'hBA);
    repeat (2) @(negedge clk);

    // Largest dwell: 256 cycles per vector.
    scan(8'd255, 8'h5C, 2048, "dwell255");

`ifdef COMBI_SCAN_COMPARE_EN
    bus.expected = 8'hBA;
    scan(8'd2, 8'hBA, 24, "t6 match");
    chk("t6 pass lit", bus.pass, 1'b1);
    bus.expected = 8'hB8;
    scan(8'd2, 8'hBA, 24, "t6 differ");
    chk("t6 mismatch lit", bus.mismatch, 8'h02);
    chk("t6 pass held", bus.pass, 1'b0);
`endif

    // Randomized traffic: random start, dwell, tables and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.dwell = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(6, 12)) : 8'($urandom_range(0, 5));
      if (!m_active) tbl = 8'($urandom);
`ifdef COMBI_SCAN_COMPARE_EN
      bus.expected = ($urandom_range(0, 1) == 0) ? tbl : 8'($urandom);
`endif
    end
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (120) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
